// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// Optional feature: ASYNC_FIFO_LEVEL_EN adds the occupancy (level) output.
package async_fifo_pkg;

   localparam int unsigned DefaultDataWidth = 8;
   localparam int unsigned DefaultAddrWidth = 3;

   // Pointer carries one extra wrap bit above the memory address.
   typedef logic [DefaultAddrWidth:0]    ptr_t;
   typedef logic [DefaultDataWidth-1:0]  data_t;

endpackage

// File: rtl/async_fifo_core_if.sv
// Handshake bundle between the FIFO (slave) and its producer/consumer (master).
// With ASYNC_FIFO_LEVEL_EN defined the bundle also carries the occupancy count.
interface async_fifo_core_if
   import async_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) ();

   logic                  wreq;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  rreq;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  wfull;
   logic                  rempty;
`ifdef ASYNC_FIFO_LEVEL_EN
   logic [ADDR_WIDTH:0]   level;

   modport master (
      output wreq, wdata, rreq,
      input  rdata, wfull, rempty, level
   );

   modport slave (
      input  wreq, wdata, rreq,
      output rdata, wfull, rempty, level
   );
`else
   modport master (
      output wreq, wdata, rreq,
      input  rdata, wfull, rempty
   );

   modport slave (
      input  wreq, wdata, rreq,
      output rdata, wfull, rempty
   );
`endif

endinterface

// File: rtl/async_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// Storage is never reset; only the read-data register is.
module async_fifo_mem
   import async_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [DATA_WIDTH-1:0] mem_d [Depth];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   // Next-state of storage and read register; read sees the pre-edge contents.
   always_comb begin
      mem_d   = mem_q;
      rdata_d = rdata_q;
      if (we_i) begin
         mem_d[waddr_i] = wdata_i;
      end
      if (re_i) begin
         rdata_d = mem_q[raddr_i];
      end
   end

   // Storage array, deliberately without reset.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   // Read data register, cleared by reset and held when no read is accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   always_comb rdata_o = rdata_q;

endmodule

// File: rtl/async_fifo_core.sv
// Single-clock FIFO: pointer/flag logic around async_fifo_mem.
// Define ASYNC_FIFO_LEVEL_EN to add the registered occupancy output (bus.level).
module async_fifo_core
   import async_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
   input  logic              wclk,
   input  logic              wrst_n,
   async_fifo_core_if.slave  bus
);

   logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
   logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
   logic                  full, empty;
   logic                  wr_en, rd_en;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Flags come from the registered pointers only; both requests are judged
   // against the pre-edge flags, so full+both reads only and empty+both writes only.
   always_comb begin
      empty  = (wptr_q == rptr_q);
      full   = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
               (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
      wr_en  = bus.wreq && !full;
      rd_en  = bus.rreq && !empty;
      wptr_d = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
      rptr_d = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
   end

   // Pointer registers; wrap bit rolls over naturally modulo 2**(ADDR_WIDTH+1).
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   async_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (wclk),
      .rst_ni  (wrst_n),
      .we_i    (wr_en),
      .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
      .wdata_i (bus.wdata),
      .re_i    (rd_en),
      .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (mem_rdata)
   );

   // Drive status and data outputs onto the bundle.
   always_comb begin
      bus.rdata  = mem_rdata;
      bus.wfull  = full;
      bus.rempty = empty;
   end

`ifdef ASYNC_FIFO_LEVEL_EN
   logic [ADDR_WIDTH:0] level_q, level_d;

   // Occupancy tracks the next pointers so it updates on the same edge they do.
   always_comb begin
      level_d = wptr_d - rptr_d;
   end

   // Occupancy register.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   // Expose occupancy.
   always_comb bus.level = level_q;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Self-checking bench for async_fifo_core: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
// Honors ASYNC_FIFO_LEVEL_EN when the design is built with it.
module tb_async_fifo_core;

   localparam int unsigned Depth = 8;

   logic wclk;
   logic wrst_n;

   async_fifo_core_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

   async_fifo_core #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (3)
   ) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0] q [$];
   logic [7:0] m_rdata  = 8'd0;
   bit         model_on = 1'b0;
   bit         m_aw, m_ar;

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: requests judged on the occupancy before the edge.
   always @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         q.delete();
         m_rdata  = 8'd0;
         model_on = 1'b1;
      end else begin
         m_aw = bus.wreq && (q.size() < Depth);
         m_ar = bus.rreq && (q.size() != 0);
         if (m_ar) m_rdata = q.pop_front();
         if (m_aw) q.push_back(bus.wdata);
      end
   end

   // Per-cycle comparison away from the active edge.
   always @(negedge wclk) begin
      if (model_on) begin
         check("cmp_rdata", 32'(bus.rdata), 32'(m_rdata));
         check("cmp_rempty", 32'(bus.rempty), 32'(q.size() == 0));
         check("cmp_wfull", 32'(bus.wfull), 32'(q.size() == Depth));
`ifdef ASYNC_FIFO_LEVEL_EN
         check("cmp_level", 32'(bus.level), 32'(q.size()));
`endif
      end
   end

   // One clock cycle: drive after negedge, return 2 units after the posedge.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r);
      @(negedge wclk);
      #1;
      bus.wreq  = w;
      bus.wdata = d;
      bus.rreq  = r;
      @(posedge wclk);
      #2;
   endtask

   logic [7:0] fill_vals [8] = '{8'd4, 8'd15, 8'd19, 8'd107, 8'd5, 8'd8, 8'd50, 8'd244};

   initial begin
      bus.wreq  = 1'b0;
      bus.rreq  = 1'b0;
      bus.wdata = 8'd0;
      wrst_n    = 1'b1;
      #2 wrst_n = 1'b0;
      #10;
      check("reset_rempty", 32'(bus.rempty), 32'd1);
      check("reset_wfull", 32'(bus.wfull), 32'd0);
      check("reset_rdata", 32'(bus.rdata), 32'd0);
`ifdef ASYNC_FIFO_LEVEL_EN
      check("reset_level", 32'(bus.level), 32'd0);
`endif
      #5 wrst_n = 1'b1;

      // Fill
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, fill_vals[i], 1'b0);
         if (i == 0) check("fill_rempty_clear", 32'(bus.rempty), 32'd0);
         if (i < 7)  check("fill_not_full", 32'(bus.wfull), 32'd0);
      end
      check("fill_full", 32'(bus.wfull), 32'd1);
      cyc(1'b1, 8'd67, 1'b0);
      check("drop_full", 32'(bus.wfull), 32'd1);
      check("drop_rdata", 32'(bus.rdata), 32'd0);

      // Drain
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 8'd0, 1'b1);
         check("drain_rdata", 32'(bus.rdata), 32'(fill_vals[i]));
      end
      check("drain_empty", 32'(bus.rempty), 32'd1);
      cyc(1'b0, 8'd0, 1'b1);
      check("drain_hold", 32'(bus.rdata), 32'd244);

      // Streaming across the pointer wrap
      for (int i = 0; i < 15; i++) begin
         cyc(1'b1, 8'(8'h10 + i), 1'b1);
         if (i > 0) check("stream_rdata", 32'(bus.rdata), 32'(8'h10 + i - 1));
         check("stream_not_full", 32'(bus.wfull), 32'd0);
      end
      cyc(1'b0, 8'd0, 1'b1);
      check("stream_last", 32'(bus.rdata), 32'h1e);
      check("stream_empty", 32'(bus.rempty), 32'd1);

      // Simultaneous requests at full
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
      check("bfull_full", 32'(bus.wfull), 32'd1);
      cyc(1'b1, 8'h99, 1'b1);
      check("bfull_rdata", 32'(bus.rdata), 32'h80);
      check("bfull_wfull", 32'(bus.wfull), 32'd0);
`ifdef ASYNC_FIFO_LEVEL_EN
      check("bfull_level", 32'(bus.level), 32'd7);
`endif
      for (int i = 0; i < 7; i++) cyc(1'b0, 8'd0, 1'b1);
      check("bfull_drain_last", 32'(bus.rdata), 32'h87);
      check("bfull_drain_empty", 32'(bus.rempty), 32'd1);

      // Simultaneous requests at empty
      cyc(1'b1, 8'h55, 1'b1);
      check("bempty_rdata_hold", 32'(bus.rdata), 32'h87);
      check("bempty_rempty", 32'(bus.rempty), 32'd0);
      cyc(1'b0, 8'd0, 1'b1);
      check("bempty_read", 32'(bus.rdata), 32'h55);

      // Mid-operation asynchronous reset
      for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0);
      @(negedge wclk);
      #2;
      bus.wreq  = 1'b0;
      bus.rreq  = 1'b0;
      wrst_n    = 1'b0;
      #1;
      check("mrst_rempty", 32'(bus.rempty), 32'd1);
      check("mrst_wfull", 32'(bus.wfull), 32'd0);
      check("mrst_rdata", 32'(bus.rdata), 32'd0);
      #1 wrst_n = 1'b1;
      cyc(1'b1, 8'hA5, 1'b0);
      check("mrst_write", 32'(bus.rempty), 32'd0);
      cyc(1'b0, 8'd0, 1'b1);
      check("mrst_read", 32'(bus.rdata), 32'hA5);
      check("mrst_empty", 32'(bus.rempty), 32'd1);

      // Randomized traffic with shifting bias to visit full and empty often
      for (int i = 0; i < 600; i++) begin
         int wb;
         wb = (i < 200) ? 75 : (i < 400) ? 30 : 55;
         cyc(1'($urandom_range(0, 99) < wb), 8'($urandom), 1'($urandom_range(0, 99) < 50));
      end
      cyc(1'b0, 8'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
